crc32k_check_16: RTL and testbench

CRC32K_CHECK_16 -- requirements
Module: crc32k_check_16

---
 rtl/crc32k_check_16.sv | 174 +++++++++++++++++
 tb/tb_crc32k_check_16.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc32k_check_16.sv
// crc32k_check_16: receive-side CRC-32K checker for 16-bit framed words.
// The last two words of each frame carry the transmitted CRC (high half
// first). A two-word delay buffer keeps those words out of the running CRC
// until the frame end is known.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   word handshake (accept = in_valid & in_ready)
//   in_sop/in_eop       first/last word of frame markers
//   in_data[15:0]       frame word, bit 0 first on the serial line
//   frame_done          one-cycle pulse, status outputs valid
//   crc_ok/crc_err      CRC match / mismatch-or-runt
//   runt                frame shorter than 3 words
//   crc_value[31:0]     CRC over the data words of the last frame
//   word_count[15:0]    data words in the last frame (saturating)
module crc32k_check_16 #(
  parameter logic [31:0] SEED = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic [15:0] in_data,
  output logic        frame_done,
  output logic        crc_ok,
  output logic        crc_err,
  output logic        runt,
  output logic [31:0] crc_value,
  output logic [15:0] word_count
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CRC_W  = 32;
  localparam int unsigned CNT_W  = 16;
  localparam logic [CRC_W-1:0] POLY = 32'h741B_8CD7;

  // FILL1/FILL2 encode the delay-buffer fill count (1 and 2 words held).
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL1 = 3'd1,
    FILL2 = 3'd2,
    RUN   = 3'd3,
    CHECK = 3'd4
  } state_t;

  state_t            r_state;
  logic [CRC_W-1:0]  r_crc;
  logic [CRC_W-1:0]  r_rx_crc;
  logic [DATA_W-1:0] r_b0;
  logic [DATA_W-1:0] r_b1;
  logic [CNT_W-1:0]  r_count;
  logic              r_runt_pend;
  logic              r_in_ready;
  logic              r_frame_done;
  logic              r_crc_ok;
  logic              r_crc_err;
  logic              r_runt;
  logic [CRC_W-1:0]  r_crc_value;
  logic [CNT_W-1:0]  r_word_count;

  logic              w_accept;
  logic [CRC_W-1:0]  w_crc_next;

  // One word through the serial CRC, bit 0 first.
  function automatic logic [CRC_W-1:0] step16(input logic [CRC_W-1:0] s,
                                              input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] v;
    v = s;
    for (int i = 0; i < DATA_W; i++) begin
      v = {v[CRC_W-2:0], d[i]} ^ (v[CRC_W-1] ? POLY : CRC_W'(0));
    end
    return v;
  endfunction

  assign w_accept   = in_valid & r_in_ready;
  assign w_crc_next = step16(r_crc, r_b0);

  // Frame FSM, delay buffer, CRC accumulation and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_crc        <= SEED;
      r_rx_crc     <= '0;
      r_b0         <= '0;
      r_b1         <= '0;
      r_count      <= '0;
      r_runt_pend  <= 1'b0;
      r_in_ready   <= 1'b1;
      r_frame_done <= 1'b0;
      r_crc_ok     <= 1'b0;
      r_crc_err    <= 1'b0;
      r_runt       <= 1'b0;
      r_crc_value  <= '0;
      r_word_count <= '0;
    end else begin
      r_frame_done <= 1'b0;
      if (r_state == CHECK) begin
        r_state      <= IDLE;
        r_in_ready   <= 1'b1;
        r_frame_done <= 1'b1;
        r_runt       <= r_runt_pend;
        if (r_runt_pend) begin
          r_crc_ok     <= 1'b0;
          r_crc_err    <= 1'b1;
          r_crc_value  <= '0;
          r_word_count <= '0;
        end else begin
          r_crc_ok     <= (r_crc == r_rx_crc);
          r_crc_err    <= (r_crc != r_rx_crc);
          r_crc_value  <= r_crc;
          r_word_count <= r_count;
        end
      end else if (w_accept) begin
        if (in_sop) begin
          // Start (or silently restart) a frame from any accepting state.
          r_crc   <= SEED;
          r_b0    <= '0;
          r_b1    <= in_data;
          r_count <= '0;
          if (in_eop) begin
            r_runt_pend <= 1'b1;
            r_in_ready  <= 1'b0;
            r_state     <= CHECK;
          end else begin
            r_runt_pend <= 1'b0;
            r_state     <= FILL1;
          end
        end else begin
          unique case (r_state)
            IDLE: ; // words outside a frame are dropped
            FILL1: begin
              r_b0 <= r_b1;
              r_b1 <= in_data;
              if (in_eop) begin
                r_runt_pend <= 1'b1;
                r_in_ready  <= 1'b0;
                r_state     <= CHECK;
              end else begin
                r_state <= FILL2;
              end
            end
            FILL2, RUN: begin
              // b0 is now known not to be part of the CRC field.
              r_crc   <= w_crc_next;
              r_b0    <= r_b1;
              r_b1    <= in_data;
              r_count <= (r_count == '1) ? r_count : r_count + CNT_W'(1);
              if (in_eop) begin
                r_rx_crc    <= {r_b1, in_data};
                r_runt_pend <= 1'b0;
                r_in_ready  <= 1'b0;
                r_state     <= CHECK;
              end else begin
                r_state <= RUN;
              end
            end
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign frame_done = r_frame_done;
  assign crc_ok     = r_crc_ok;
  assign crc_err    = r_crc_err;
  assign runt       = r_runt;
  assign crc_value  = r_crc_value;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_crc32k_check_16.sv
// Bench for crc32k_check_16 (SEED=0): frames are driven through a handshake
// task, expected status records are queued at frame start and compared when
// frame_done pulses.
module tb_crc32k_check_16;

  localparam logic [31:0] POLY = 32'h741B_8CD7;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sop;
  logic        in_eop;
  logic [15:0] in_data;
  logic        frame_done;
  logic        crc_ok;
  logic        crc_err;
  logic        runt;
  logic [31:0] crc_value;
  logic [15:0] word_count;

  crc32k_check_16 #(.SEED(32'h0)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
    .frame_done(frame_done), .crc_ok(crc_ok), .crc_err(crc_err),
    .runt(runt), .crc_value(crc_value), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ok;
    logic        err;
    logic        rnt;
    logic [31:0] value;
    logic [15:0] count;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] frm[$];
  int          n_total = 0;
  int          n_bad   = 0;
  int          n_done  = 0;
  int          last_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference CRC: shift each bit in, then reduce when the bit shifted out was 1.
  function automatic logic [31:0] ref_crc(input logic [15:0] w[$], input int n);
    logic [31:0] c;
    logic        top;
    c = 32'h0;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 16; b++) begin
        top = c[31];
        c   = (c << 1) | 32'(w[i][b]);
        if (top) c = c ^ POLY;
      end
    end
    return c;
  endfunction

  function automatic exp_t model(input logic [15:0] w[$]);
    exp_t        e;
    int          n;
    logic [31:0] c;
    logic [31:0] rx;
    n = w.size();
    if (n < 3) begin
      e = '{ok: 1'b0, err: 1'b1, rnt: 1'b1, value: 32'h0, count: 16'h0};
    end else begin
      c  = ref_crc(w, n - 2);
      rx = {w[n-2], w[n-1]};
      e  = '{ok: (c == rx), err: (c != rx), rnt: 1'b0, value: c, count: 16'(n - 2)};
    end
    return e;
  endfunction

  // Present one word and hold it until accepted; last_stall = cycles waited.
  task automatic send_word(input logic [15:0] d, input logic sop, input logic eop);
    int guard;
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = sop;
    in_eop   = eop;
    guard    = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    last_stall = guard;
    if (guard >= 100) check("ready_timeout", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input bit keep_valid);
    for (int i = 0; i < frm.size(); i++)
      send_word(frm[i], i == 0, i == frm.size() - 1);
    if (!keep_valid) begin
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Random data frame with its CRC appended; optionally corrupted.
  task automatic build_random(input int ndata, input bit corrupt);
    logic [31:0] c;
    frm = {};
    for (int i = 0; i < ndata; i++) frm.push_back(16'($urandom));
    c = ref_crc(frm, ndata);
    if (corrupt) c = c ^ (32'h1 << $urandom_range(31, 0));
    frm.push_back(c[31:16]);
    frm.push_back(c[15:0]);
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && frame_done) begin
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'h1, 32'h0);
      end else begin
        e = sb.pop_front();
        check("crc_ok",     32'(crc_ok),     32'(e.ok));
        check("crc_err",    32'(crc_err),    32'(e.err));
        check("runt",       32'(runt),       32'(e.rnt));
        check("crc_value",  crc_value,       e.value);
        check("word_count", 32'(word_count), 32'(e.count));
      end
    end
  end

  initial begin
    int d0;
    rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
    idle_cycles(3);
    rst = 1'b0;
    #1;
    check("rst_ready",  32'(in_ready),   32'h1);
    check("rst_done",   32'(frame_done), 32'h0);
    check("rst_ok",     32'(crc_ok),     32'h0);
    check("rst_err",    32'(crc_err),    32'h0);
    check("rst_runt",   32'(runt),       32'h0);
    check("rst_value",  crc_value,       32'h0);
    check("rst_count",  32'(word_count), 32'h0);

    // All-zero frame, with latency checks around the eop.
    frm = '{16'h0000, 16'h0000, 16'h0000};
    sb.push_back('{ok: 1'b1, err: 1'b0, rnt: 1'b0, value: 32'h0, count: 16'd1});
    send_frame(1'b0);
    check("lat_check_done", 32'(frame_done), 32'h0);
    check("lat_check_rdy",  32'(in_ready),   32'h0);
    idle_cycles(1);
    check("lat_pulse",      32'(frame_done), 32'h1);
    check("lat_rdy_back",   32'(in_ready),   32'h1);
    idle_cycles(1);
    check("lat_pulse_end",  32'(frame_done), 32'h0);
    check("hold_ok",        32'(crc_ok),     32'h1);
    idle_cycles(2);

    // Single data bit lands at position 15.
    frm = '{16'h0001, 16'h0000, 16'h8000};
    sb.push_back('{ok: 1'b1, err: 1'b0, rnt: 1'b0, value: 32'h0000_8000, count: 16'd1});
    send_frame(1'b0);
    idle_cycles(3);
    frm = '{16'h0001, 16'h0000, 16'h8001};
    sb.push_back('{ok: 1'b0, err: 1'b1, rnt: 1'b0, value: 32'h0000_8000, count: 16'd1});
    send_frame(1'b0);
    idle_cycles(3);

    // Runts.
    frm = '{16'h1234};
    sb.push_back('{ok: 1'b0, err: 1'b1, rnt: 1'b1, value: 32'h0, count: 16'd0});
    send_frame(1'b0);
    idle_cycles(3);
    frm = '{16'h1234, 16'h5678};
    sb.push_back('{ok: 1'b0, err: 1'b1, rnt: 1'b1, value: 32'h0, count: 16'd0});
    send_frame(1'b0);
    idle_cycles(3);

    // Frame abandoned by a second sop; only the second one reports.
    d0 = n_done;
    send_word(16'hAAAA, 1'b1, 1'b0);
    send_word(16'hBBBB, 1'b0, 1'b0);
    frm = '{16'h0001, 16'h0000, 16'h8000};
    sb.push_back('{ok: 1'b1, err: 1'b0, rnt: 1'b0, value: 32'h0000_8000, count: 16'd1});
    send_frame(1'b0);
    idle_cycles(3);
    check("restart_done_cnt", 32'(n_done - d0), 32'h1);

    // Reset mid-frame, then a clean random frame.
    d0 = n_done;
    send_word(16'h1111, 1'b1, 1'b0);
    send_word(16'h2222, 1'b0, 1'b0);
    send_word(16'h3333, 1'b0, 1'b0);
    send_word(16'h4444, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0;
    idle_cycles(3);
    check("rst_abort_no_done", 32'(n_done - d0), 32'h0);
    build_random(5, 1'b0);
    sb.push_back(model(frm));
    send_frame(1'b0);
    idle_cycles(3);
    check("rst_new_done_cnt", 32'(n_done - d0), 32'h1);

    // Back-to-back frames with in_valid held high.
    d0 = n_done;
    build_random(1, 1'b0);
    sb.push_back(model(frm));
    send_frame(1'b1);
    build_random(6, 1'b1);
    sb.push_back(model(frm));
    send_frame(1'b1);
    check("b2b_stall_1", 32'(last_stall == 1 || frm.size() > 1), 32'h1);
    build_random(9, 1'b0);
    sb.push_back(model(frm));
    for (int i = 0; i < frm.size(); i++) begin
      send_word(frm[i], i == 0, i == frm.size() - 1);
      if (i == 0) check("b2b_stall_first", 32'(last_stall), 32'h1);
      else if (i == 1) check("b2b_no_stall", 32'(last_stall), 32'h0);
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    idle_cycles(3);
    check("b2b_done_cnt", 32'(n_done - d0), 32'h3);

    // A few more random frames, some corrupted.
    for (int k = 0; k < 6; k++) begin
      build_random($urandom_range(12, 1), k[0]);
      sb.push_back(model(frm));
      send_frame(1'b0);
      idle_cycles($urandom_range(3, 0));
    end
    idle_cycles(5);
    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
